// File: rtl/addr_arb_pkg.sv
// Shared definitions for the address-channel arbiter.
//   arb_state_t   : arbiter FSM encoding (IDLE, ADDR, DATA)
//   REGION_NIBBLE : addr[31:28] value owning each router slave index
//   decode_slave  : maps an address onto {hit, slave index}
package addr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  localparam int NUM_REGIONS = 5;
  localparam int SLAVE_W     = 3;

  // Entry i is the top address nibble routed to slave index i.
  localparam logic [3:0] REGION_NIBBLE [NUM_REGIONS] = '{4'h0, 4'h2, 4'h4, 4'h8, 4'hF};

  typedef struct packed {
    logic               hit;
    logic [SLAVE_W-1:0] idx;
  } decode_t;

  function automatic decode_t decode_slave(input logic [31:0] addr);
    decode_t d;
    d.hit = 1'b0;
    d.idx = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (!d.hit && (addr[31:28] == REGION_NIBBLE[i])) begin
        d.hit = 1'b1;
        d.idx = SLAVE_W'(i);
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/addr_channel_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : request vector, one bit per requester
//   ptr       : highest-priority requester this cycle
//   grant     : one-hot grant (zero when no request)
//   grant_idx : index of the granted requester
//   any       : at least one request present
// Scans upward from ptr with wrap-around; the first set request wins.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  always_comb begin
    int j;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    j         = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!any && req[j]) begin
        any       = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/addr_channel_arbiter.sv
// Address-channel arbiter in front of address_router.
// Picks one of NUM_MASTERS requesters round-robin, latches its request,
// decodes the slave index, presents it to the router and keeps ownership
// until the burst's data beats are done.
//   m_*        : per-master request (m_ready is the one-hot acceptance)
//   r_*        : request towards the router (r_valid/r_ready handshake)
//   d_fire/d_last : data beats of the granted burst
//   grant_q    : current/last owner;  busy : FSM outside IDLE
//   decerr     : pulse, accepted address matched no slave
//   burst_err  : pulse, d_last disagreed with the beat count
//   state_dbg  : FSM state for observation
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high; valid never waits on ready, and the payload is held while valid is
// high and ready is low.
module addr_channel_arbiter
  import addr_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int NUM_SLAVES  = 5,
  parameter int MIDX_W      = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_MASTERS-1:0][31:0] m_addr,
  input  logic [NUM_MASTERS-1:0][7:0]  m_len,
  input  logic [NUM_MASTERS-1:0][2:0]  m_size,
  input  logic [NUM_MASTERS-1:0][1:0]  m_burst,
  input  logic [NUM_MASTERS-1:0]       m_valid,
  output logic [NUM_MASTERS-1:0]       m_ready,
  output logic [31:0]                  r_addr,
  output logic [7:0]                   r_len,
  output logic [2:0]                   r_size,
  output logic [1:0]                   r_burst,
  output logic                         r_valid,
  input  logic                         r_ready,
  output logic [2:0]                   r_slave,
  input  logic                         d_fire,
  input  logic                         d_last,
  output logic [MIDX_W-1:0]            grant_q,
  output logic                         busy,
  output logic                         decerr,
  output logic                         burst_err,
  output arb_state_t                   state_dbg
);

  arb_state_t              state_q, state_d;
  logic [MIDX_W-1:0]       rr_ptr;
  logic [7:0]              beat_q;
  logic [NUM_MASTERS-1:0]  grant_oh;
  logic [MIDX_W-1:0]       grant_idx;
  logic                    any_req;
  decode_t                 dec;
  logic                    dec_hit;
  logic                    accept;
  logic                    finish;
  logic                    berr_d;

  rr_arbiter #(.N(NUM_MASTERS), .IDX_W(MIDX_W)) u_rr (
    .req       (m_valid),
    .ptr       (rr_ptr),
    .grant     (grant_oh),
    .grant_idx (grant_idx),
    .any       (any_req)
  );

  // Decode straight from the winner's input; the result is latched with it.
  // A region beyond the configured slave count is treated as a miss.
  assign dec     = decode_slave(m_addr[grant_idx]);
  assign dec_hit = dec.hit && (int'(dec.idx) < NUM_SLAVES);

  always_comb begin
    state_d = state_q;
    m_ready = '0;
    accept  = 1'b0;
    finish  = 1'b0;
    berr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // Gated by reset so no master sees an acceptance that is not latched.
        if (any_req && !reset) begin
          m_ready = grant_oh;
          accept  = 1'b1;
          state_d = dec_hit ? ADDR : IDLE;
        end
      end
      ADDR: begin
        if (r_ready) state_d = DATA;
      end
      DATA: begin
        if (d_fire) begin
          if (beat_q == r_len) begin
            finish = 1'b1;
            berr_d = !d_last;
          end else if (d_last) begin
            finish = 1'b1;
            berr_d = 1'b1;
          end
        end
        if (finish) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_ptr    <= '0;
      beat_q    <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      r_slave   <= '0;
      grant_q   <= '0;
      decerr    <= 1'b0;
      burst_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      decerr    <= accept && !dec_hit;
      burst_err <= berr_d;
      if (accept) begin
        r_addr  <= m_addr[grant_idx];
        r_len   <= m_len[grant_idx];
        r_size  <= m_size[grant_idx];
        r_burst <= m_burst[grant_idx];
        r_slave <= dec.idx;
        grant_q <= grant_idx;
        rr_ptr  <= (grant_idx == MIDX_W'(NUM_MASTERS - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (finish) begin
        beat_q <= '0;
      end else if ((state_q == DATA) && d_fire) begin
        beat_q <= beat_q + 8'd1;
      end
    end
  end

  assign r_valid   = (state_q == ADDR);
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_addr_channel_arbiter.sv
// Directed bench for addr_channel_arbiter: each scenario task drives the
// inputs and compares outputs against hand-computed values.
module tb_addr_channel_arbiter;
  import addr_arb_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic [3:0][31:0]  m_addr;
  logic [3:0][7:0]   m_len;
  logic [3:0][2:0]   m_size;
  logic [3:0][1:0]   m_burst;
  logic [3:0]        m_valid;
  logic [3:0]        m_ready;
  logic [31:0]       r_addr;
  logic [7:0]        r_len;
  logic [2:0]        r_size;
  logic [1:0]        r_burst;
  logic              r_valid;
  logic              r_ready;
  logic [2:0]        r_slave;
  logic              d_fire;
  logic              d_last;
  logic [1:0]        grant_q;
  logic              busy;
  logic              decerr;
  logic              burst_err;
  arb_state_t        state_dbg;

  int errors = 0;
  int checks = 0;

  // clock / reset block
  always #5 clk = ~clk;

  addr_channel_arbiter #(.NUM_MASTERS(4), .NUM_SLAVES(5), .MIDX_W(2)) dut (
    .clk(clk), .reset(reset),
    .m_addr(m_addr), .m_len(m_len), .m_size(m_size), .m_burst(m_burst),
    .m_valid(m_valid), .m_ready(m_ready),
    .r_addr(r_addr), .r_len(r_len), .r_size(r_size), .r_burst(r_burst),
    .r_valid(r_valid), .r_ready(r_ready), .r_slave(r_slave),
    .d_fire(d_fire), .d_last(d_last),
    .grant_q(grant_q), .busy(busy), .decerr(decerr), .burst_err(burst_err),
    .state_dbg(state_dbg)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int m, input logic [31:0] a, input logic [7:0] l);
    m_addr[m]  = a;
    m_len[m]   = l;
    m_size[m]  = 3'd2;
    m_burst[m] = 2'd1;
  endtask

  // One data beat; d_fire is dropped afterwards.
  task automatic beat(input logic last);
    d_fire = 1'b1;
    d_last = last;
    tick();
    d_fire = 1'b0;
    d_last = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL reset_r_valid: got %b exp 0", r_valid); end
    checks++; if (m_ready !== 4'b0) begin errors++; $display("FAIL reset_m_ready: got %b exp 0000", m_ready); end
    checks++; if (grant_q !== 2'd0) begin errors++; $display("FAIL reset_grant_q: got %0d exp 0", grant_q); end
    checks++; if ({r_addr, r_len, r_slave} !== 43'd0) begin errors++; $display("FAIL reset_r_fields: got %h/%h/%h exp 0", r_addr, r_len, r_slave); end
    checks++; if ({decerr, burst_err} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b exp 00", {decerr, burst_err}); end
    checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL reset_state: got %0d exp 0", state_dbg); end
  endtask

  task automatic test_single();
    set_req(0, 32'h0000_0010, 8'd7);
    m_valid = 4'b0001;
    #1;
    checks++; if (m_ready !== 4'b0001) begin errors++; $display("FAIL single_m_ready: got %b exp 0001", m_ready); end
    tick();
    m_valid = 4'b0000;
    checks++; if (r_valid !== 1'b1) begin errors++; $display("FAIL single_r_valid: got %b exp 1", r_valid); end
    checks++; if (r_slave !== 3'd0) begin errors++; $display("FAIL single_r_slave: got %0d exp 0", r_slave); end
    checks++; if (r_addr !== 32'h0000_0010 || r_len !== 8'd7) begin errors++; $display("FAIL single_r_fields: got %h/%0d exp 00000010/7", r_addr, r_len); end
    r_ready = 1'b1;
    tick();
    checks++; if (r_valid !== 1'b0 || state_dbg !== DATA) begin errors++; $display("FAIL single_to_data: got rv=%b st=%0d exp rv=0 st=2", r_valid, state_dbg); end
    for (int i = 0; i < 8; i++) begin
      beat(i == 7);
      if (i < 7) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_beat%0d: got %b exp 1", i, busy); end
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_done_busy: got %b exp 0", busy); end
    checks++; if (burst_err !== 1'b0 || decerr !== 1'b0) begin errors++; $display("FAIL single_no_err: got %b%b exp 00", burst_err, decerr); end
  endtask

  task automatic test_fairness();
    int seen[4];
    logic [1:0] exp_idx;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int m = 0; m < 4; m++) begin
      set_req(m, 32'h0000_0100 * m, 8'd0);
      seen[m] = 0;
    end
    m_valid = 4'b1111;
    r_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_idx = 2'(k % 4);
      #1;
      checks++; if (m_ready !== 4'(1 << exp_idx)) begin errors++; $display("FAIL fair_m_ready%0d: got %b exp %b", k, m_ready, 4'(1 << exp_idx)); end
      tick();
      checks++; if (grant_q !== exp_idx || r_valid !== 1'b1) begin errors++; $display("FAIL fair_grant%0d: got %0d rv=%b exp %0d rv=1", k, grant_q, r_valid, exp_idx); end
      if (k < 4) seen[grant_q]++;
      tick();
      beat(1'b1);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fair_done%0d: got busy=%b exp 0", k, busy); end
    end
    m_valid = 4'b0000;
    for (int m = 0; m < 4; m++) begin
      checks++; if (seen[m] != 1) begin errors++; $display("FAIL fair_seen%0d: got %0d exp 1", m, seen[m]); end
    end
  endtask

  task automatic test_back_pressure();
    set_req(2, 32'hF001_0004, 8'd0);
    m_valid = 4'b0100;
    r_ready = 1'b0;
    #1;
    checks++; if (m_ready !== 4'b0100) begin errors++; $display("FAIL bp_m_ready: got %b exp 0100", m_ready); end
    tick();
    set_req(0, 32'h0000_0040, 8'd0);
    m_valid = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (r_valid !== 1'b1 || r_addr !== 32'hF001_0004 || r_slave !== 3'd4) begin errors++; $display("FAIL bp_hold%0d: got rv=%b a=%h s=%0d exp rv=1 a=f0010004 s=4", i, r_valid, r_addr, r_slave); end
      checks++; if (m_ready !== 4'b0000) begin errors++; $display("FAIL bp_no_ready%0d: got %b exp 0000", i, m_ready); end
      tick();
    end
    r_ready = 1'b1;
    tick();
    checks++; if (r_valid !== 1'b0 || state_dbg !== DATA || grant_q !== 2'd2) begin errors++; $display("FAIL bp_data: got rv=%b st=%0d g=%0d exp rv=0 st=2 g=2", r_valid, state_dbg, grant_q); end
    checks++; if (m_ready !== 4'b0000) begin errors++; $display("FAIL bp_no_ready_data: got %b exp 0000", m_ready); end
    beat(1'b1);
    checks++; if (busy !== 1'b0 || burst_err !== 1'b0) begin errors++; $display("FAIL bp_done: got busy=%b be=%b exp 0 0", busy, burst_err); end
    // The master that waited through the burst is served next.
    checks++; if (m_ready !== 4'b0001) begin errors++; $display("FAIL bp_waiter_ready: got %b exp 0001", m_ready); end
    tick();
    m_valid = 4'b0000;
    checks++; if (grant_q !== 2'd0 || r_addr !== 32'h0000_0040) begin errors++; $display("FAIL bp_waiter_grant: got g=%0d a=%h exp 0 00000040", grant_q, r_addr); end
    tick();
    beat(1'b1);
  endtask

  task automatic test_decerr();
    set_req(3, 32'h3000_0000, 8'd0);
    m_valid = 4'b1000;
    #1;
    checks++; if (m_ready !== 4'b1000) begin errors++; $display("FAIL dec_m_ready: got %b exp 1000", m_ready); end
    tick();
    set_req(1, 32'h2000_1000, 8'd0);
    m_valid = 4'b0010;
    #1;
    checks++; if (decerr !== 1'b1 || r_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL dec_pulse: got de=%b rv=%b busy=%b exp 1 0 0", decerr, r_valid, busy); end
    checks++; if (m_ready !== 4'b0010) begin errors++; $display("FAIL dec_next_ready: got %b exp 0010", m_ready); end
    tick();
    m_valid = 4'b0000;
    checks++; if (decerr !== 1'b0 || r_valid !== 1'b1 || r_slave !== 3'd1 || grant_q !== 2'd1) begin errors++; $display("FAIL dec_next_served: got de=%b rv=%b s=%0d g=%0d exp 0 1 1 1", decerr, r_valid, r_slave, grant_q); end
    tick();
    beat(1'b1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dec_next_done: got %b exp 0", busy); end
  endtask

  task automatic test_burst_err();
    set_req(2, 32'h4000_0000, 8'd3);
    m_valid = 4'b0100;
    tick();
    m_valid = 4'b0000;
    checks++; if (r_slave !== 3'd2 || grant_q !== 2'd2) begin errors++; $display("FAIL berr1_grant: got s=%0d g=%0d exp 2 2", r_slave, grant_q); end
    tick();
    beat(1'b0);
    checks++; if (busy !== 1'b1 || burst_err !== 1'b0) begin errors++; $display("FAIL berr1_mid: got busy=%b be=%b exp 1 0", busy, burst_err); end
    beat(1'b1);
    checks++; if (burst_err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL berr1_early: got be=%b busy=%b exp 1 0", burst_err, busy); end
    tick();
    checks++; if (burst_err !== 1'b0) begin errors++; $display("FAIL berr1_pulse_width: got %b exp 0", burst_err); end

    set_req(3, 32'h8000_0000, 8'd3);
    m_valid = 4'b1000;
    tick();
    m_valid = 4'b0000;
    checks++; if (r_slave !== 3'd3 || grant_q !== 2'd3) begin errors++; $display("FAIL berr2_grant: got s=%0d g=%0d exp 3 3", r_slave, grant_q); end
    tick();
    for (int i = 0; i < 3; i++) begin
      beat(1'b0);
      checks++; if (busy !== 1'b1 || burst_err !== 1'b0) begin errors++; $display("FAIL berr2_beat%0d: got busy=%b be=%b exp 1 0", i, busy, burst_err); end
    end
    beat(1'b0);
    checks++; if (burst_err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL berr2_missing_last: got be=%b busy=%b exp 1 0", burst_err, busy); end
  endtask

  task automatic test_reset_mid_burst();
    set_req(2, 32'h0000_0200, 8'd7);
    m_valid = 4'b0100;
    tick();
    m_valid = 4'b0000;
    tick();
    beat(1'b0);
    beat(1'b0);
    checks++; if (state_dbg !== DATA) begin errors++; $display("FAIL rst_mid_in_data: got %0d exp 2", state_dbg); end
    reset = 1'b1;
    set_req(1, 32'h0000_0300, 8'd0);
    set_req(3, 32'h0000_0400, 8'd0);
    m_valid = 4'b1010;
    #1;
    checks++; if (m_ready !== 4'b0000) begin errors++; $display("FAIL rst_mid_ready_in_reset: got %b exp 0000", m_ready); end
    tick();
    checks++; if ({busy, r_valid, decerr, burst_err} !== 4'b0 || grant_q !== 2'd0) begin errors++; $display("FAIL rst_mid_outputs: got busy/rv/de/be=%b g=%0d exp 0000 0", {busy, r_valid, decerr, burst_err}, grant_q); end
    checks++; if ({r_addr, r_len, r_slave} !== 43'd0) begin errors++; $display("FAIL rst_mid_r_fields: got %h/%h/%h exp 0", r_addr, r_len, r_slave); end
    reset = 1'b0;
    #1;
    // Pointer back at 0: master 1 wins over master 3.
    checks++; if (m_ready !== 4'b0010) begin errors++; $display("FAIL rst_mid_first_grant: got %b exp 0010", m_ready); end
    tick();
    m_valid = 4'b0000;
    tick();
    beat(1'b1);
    // A leftover beat count would keep the single-beat burst open.
    checks++; if (busy !== 1'b0 || burst_err !== 1'b0) begin errors++; $display("FAIL rst_mid_cnt_cleared: got busy=%b be=%b exp 0 0", busy, burst_err); end
  endtask

  initial begin
    reset   = 1'b1;
    m_addr  = '0;
    m_len   = '0;
    m_size  = '0;
    m_burst = '0;
    m_valid = '0;
    r_ready = 1'b0;
    d_fire  = 1'b0;
    d_last  = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_back_pressure();
    test_decerr();
    test_burst_err();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/addr_channel_arbiter.md
Name: addr_channel_arbiter

Overview:
- Shares the single address_router master port among NUM_MASTERS requesters.
- Arbitrates round-robin and decodes the winner's address into the router's slave index.
- Presents the latched request to the router, then holds the grant until the burst's data beats complete.
- Sits directly upstream of address_router and drives its m_* inputs and `slave`.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..8)
- NUM_SLAVES, 5, number of router slave ports; must match address_router num_slaves
- MIDX_W, 2, width of master index (clog2 NUM_MASTERS)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m_addr  in  NUM_MASTERS x 32  per-master request address
- m_len  in  NUM_MASTERS x 8  per-master burst length (beats-1)
- m_size  in  NUM_MASTERS x 3  per-master beat size
- m_burst  in  NUM_MASTERS x 2  per-master burst type
- m_valid  in  NUM_MASTERS  request valid per master
- m_ready  out  NUM_MASTERS  request accepted (one-hot or zero)
- r_addr  out  32  to router m_addr
- r_len  out  8  to router m_len
- r_size  out  3  to router m_size
- r_burst  out  2  to router m_burst
- r_valid  out  1  to router m_valid
- r_ready  in  1  from router m_ready
- r_slave  out  3  to router slave
- d_fire  in  1  data beat handshake of the granted burst
- d_last  in  1  last flag accompanying d_fire
- grant_q  out  MIDX_W  index of the current owner
- busy  out  1  high outside IDLE
- decerr  out  1  one-cycle pulse: accepted request hit no slave
- burst_err  out  1  one-cycle pulse: d_last disagrees with beat count

Behaviour:
- Reset: state IDLE; rr_ptr=0; all outputs 0 (r_* 0, m_ready 0, grant_q 0, busy 0, pulses 0); beat counter 0. Reset mid-burst aborts the burst with no completion pulse.
- IDLE arbitration:
  - Winner = first m_valid at or after rr_ptr, scanning upward with wrap.
  - m_ready[winner]=1 combinationally in the same cycle; that cycle is the handshake.
  - Winner's addr/len/size/burst and grant_q are latched; rr_ptr <= winner+1 mod NUM_MASTERS.
  - No m_valid: stay IDLE, m_ready=0.
- Decode of latched addr[31:28] into r_slave, using package table:
  - 0x0 -> 0
  - 0x2 -> 1
  - 0x4 -> 2
  - 0x8 -> 3
  - 0xF -> 4
  - Any other value: decerr=1 for the cycle after acceptance, no router transaction, return to IDLE. The next arbitration may accept in that same cycle.
- ADDR:
  - r_valid=1 starting the cycle after acceptance (1-cycle latency); r_* and r_slave held stable.
  - Leave on r_valid & r_ready -> DATA; r_valid deasserts the next cycle. Unbounded wait while r_ready=0.
- DATA:
  - Count d_fire beats.
  - Burst ends on the beat where count==r_len, i.e. r_len+1 beats total.
  - On that beat, d_last=0 -> burst_err pulse next cycle.
  - d_last=1 on an earlier beat -> burst_err pulse, burst ends immediately.
  - On end: state IDLE, busy=0 next cycle; counter cleared.
  - d_fire is ignored outside DATA.
- m_ready is never asserted outside IDLE. Masters that stay valid keep their position; no request is lost.
- r_len=0 gives a single-beat burst: the first d_fire ends it.
- busy=1 in ADDR and DATA; grant_q holds the owner until the next acceptance.
- Beat counter is 8 bits, compared equal to r_len; no wrap is possible before the end.

Decomposition:
- Package addr_arb_pkg holds:
  - state enum {IDLE, ADDR, DATA}
  - slave region table (nibble -> index) and NUM_REGIONS constant
  - function decode_slave(addr) returning {hit, idx}
- One sub-module, rr_arbiter (NUM_MASTERS req, rr_ptr in, one-hot grant + index out), combinational and reused elsewhere.

Test Plan:
- Single request: master 0 valid, addr 0x0000_0010, len 7 -> m_ready[0] same cycle; r_valid next cycle, r_slave=0; 8 d_fire with last on the 8th -> busy drops, no errors.
- Fairness: all 4 masters valid continuously, len 0, r_ready=1 -> grants in order 0,1,2,3,0; each grant_q seen once per 4 bursts.
- Back-pressure: master 2 addr 0xF001_0004, r_ready held 0 for 3 cycles -> r_valid and r_* stable, r_slave=4; handshake on r_ready=1, then DATA.
- Decode error: addr 0x3000_0000 -> m_ready pulses, decerr=1 one cycle, r_valid never asserts; the next request (addr 0x2000_1000) is served with r_slave=1.
- Burst errors: len 3 with d_last on beat 2 -> burst_err, early return to IDLE; len 3 with no d_last on beat 4 -> burst_err, IDLE after 4 beats.
- Reset in DATA after 2 of 8 beats -> all outputs 0 next cycle, rr_ptr=0; master 1 then granted first if it alone is valid.
